mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_store_align.sv | 40 ++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared bus widths, d_sel codes and arbiter state encoding
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [BE_W-1:0] SEL_BYTE = 4'b0001;
  localparam logic [BE_W-1:0] SEL_HALF = 4'b0011;
  localparam logic [BE_W-1:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_store_align.sv
// rtl/mem_arbiter_store_align.sv - byte-enable/data replication and legality of a RAM request
module store_align
  import mem_arbiter_pkg::*;
(
  input  logic              we,
  input  logic [BE_W-1:0]   sel,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata_out,
  output logic              legal
);

  logic [BE_W-1:0] mask;

  always_comb begin
    mask      = '0;
    wdata_out = wdata;
    legal     = 1'b0;
    case (sel)
      SEL_BYTE: begin
        mask      = SEL_BYTE << addr_lo;
        wdata_out = {4{wdata[7:0]}};
        legal     = 1'b1;
      end
      SEL_HALF: begin
        mask      = SEL_HALF << addr_lo;
        wdata_out = {2{wdata[15:0]}};
        legal     = ~addr_lo[0];
      end
      SEL_WORD: begin
        mask  = SEL_WORD;
        legal = (addr_lo == 2'b00);
      end
      default: ;
    endcase
    be = we ? mask : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single shared RAM port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1,
  parameter int MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BE_W-1:0]   d_sel,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              ram_en,
  output logic [BE_W-1:0]   ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              stall_req
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  arb_state_t state_q, state_d;
  logic          owner_q, owner_n;     // 1 = data port owns the transaction
  logic          bad_q, bad_n;         // illegal request: pass through ACCESS with ram_en low
  logic          last_d_q, last_d_n;   // round-robin pointer: data was granted last
  logic [CW-1:0] wait_q, wait_n;

  logic              ram_en_n, if_ack_n, if_err_n, d_ack_n, d_err_n;
  logic [BE_W-1:0]   ram_we_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [DATA_W-1:0] ram_wdata_n, if_rdata_n, d_rdata_n, rd_v;

  logic              gnt_d, grant, timeout;
  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   sa_be;
  logic [DATA_W-1:0] sa_wdata;
  logic              sa_legal;

  assign gnt_d    = d_req & (~if_req | DATA_FIRST | ~last_d_q);
  assign grant    = d_req | if_req;
  assign req_addr = gnt_d ? d_addr : if_addr;
  assign timeout  = (state_q == ST_ACCESS) & ~bad_q & ~ram_ready &
                    (wait_q == CW'(MAX_WAIT - 1));
  assign stall_req = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Fetches are checked as word loads so one legality rule covers both ports.
  store_align u_align (
    .we        (gnt_d & d_we),
    .sel       (gnt_d ? d_sel : SEL_WORD),
    .addr_lo   (req_addr[1:0]),
    .wdata     (d_wdata),
    .be        (sa_be),
    .wdata_out (sa_wdata),
    .legal     (sa_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      bad_q     <= 1'b0;
      last_d_q  <= 1'b0;
      wait_q    <= '0;
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_n;
      bad_q     <= bad_n;
      last_d_q  <= last_d_n;
      wait_q    <= wait_n;
      ram_en    <= ram_en_n;
      ram_we    <= ram_we_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
      if_ack    <= if_ack_n;
      if_err    <= if_err_n;
      d_ack     <= d_ack_n;
      d_err     <= d_err_n;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant) state_d = ST_ACCESS;
      ST_ACCESS: if (bad_q || ram_ready || timeout) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_n     = owner_q;
    bad_n       = bad_q;
    last_d_n    = last_d_q;
    wait_n      = wait_q;
    ram_en_n    = 1'b0;
    ram_we_n    = ram_we;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    if_ack_n    = 1'b0;
    if_err_n    = 1'b0;
    d_ack_n     = 1'b0;
    d_err_n     = 1'b0;
    rd_v        = ram_ready ? ram_rdata : '0;
    case (state_q)
      ST_IDLE: if (grant) begin
        owner_n     = gnt_d;
        last_d_n    = gnt_d;
        bad_n       = ~sa_legal;
        wait_n      = '0;
        ram_en_n    = sa_legal;
        ram_we_n    = sa_legal ? sa_be : '0;
        ram_addr_n  = {req_addr[ADDR_W-1:2], 2'b00};
        ram_wdata_n = sa_wdata;
      end
      ST_ACCESS: if (state_d == ST_RESP) begin
        ram_we_n = '0;
        if_ack_n = ~owner_q;
        d_ack_n  = owner_q;
        if_err_n = ~owner_q & (bad_q | timeout);
        d_err_n  = owner_q & (bad_q | timeout);
        if (!bad_q) begin
          if (owner_q) d_rdata_n = rd_v;
          else         if_rdata_n = rd_v;
        end
      end else begin
        ram_en_n = 1'b1;
        wait_n   = wait_q + CW'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction model
module tb_mem_arbiter;

  localparam int MW = 15;
  localparam bit DF = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack, if_err;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;
  logic        stall_req;

  int total = 0;
  int bad = 0;

  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  int          waits [$];
  int          acc_cnt = 0;
  int          acc_wait = 0;
  bit          last_d = 1'b0;

  mem_arbiter #(.DATA_FIRST(DF), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // RAM device: answers an access after the wait count queued for it
  always @(negedge clk) begin
    if (ram_en) begin
      if (acc_cnt == 0) acc_wait = (waits.size() > 0) ? waits.pop_front() : 0;
      ram_ready = (acc_cnt == acc_wait);
      ram_rdata = ram_mem[ram_addr[9:2]];
      if (ram_ready)
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) ram_mem[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
      acc_cnt++;
    end else begin
      acc_cnt   = 0;
      ram_ready = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic predict(input bit is_d, input bit we, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] wdata,
                         output bit legal, output logic [3:0] be, output logic [31:0] wd);
    int size;
    int off;
    off = int'(a % 32'd4);
    size = 4;
    legal = 1'b0;
    if (!is_d) legal = (off == 0);
    else begin
      case (sel)
        4'b0001: begin size = 1; legal = 1'b1; end
        4'b0011: begin size = 2; legal = (off % 2 == 0); end
        4'b1111: begin size = 4; legal = (off == 0); end
        default: begin size = 4; legal = 1'b0; end
      endcase
    end
    be = '0;
    wd = '0;
    for (int k = 0; k < 4; k++) begin
      if (is_d && we && legal && k >= off && k < off + size) be[k] = 1'b1;
      wd[8*k +: 8] = wdata[8*(k % size) +: 8];
    end
  endtask

  // Runs one fetch and/or one data request from an idle cycle; returns in the next idle cycle.
  task automatic run(input bit use_if, input logic [31:0] ia, input int iw,
                     input bit use_d, input bit dwe, input logic [3:0] dsel,
                     input logic [31:0] da, input logic [31:0] dwd, input int dw);
    bit          use_p [2];
    bit          lg [2];
    bit          er [2];
    bit          we [2];
    int          w [2];
    int          g [2];
    int          ac [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic [31:0] ad [2];
    int          first, nxt, last_t, eff;
    bit          en_exp;
    use_p[0] = use_if; use_p[1] = use_d;
    w[0] = iw; w[1] = dw; ad[0] = ia; ad[1] = da; we[0] = 1'b0; we[1] = dwe;
    g[0] = 0; g[1] = 0; ac[0] = 0; ac[1] = 0;
    er[0] = 1'b0; er[1] = 1'b0; rd[0] = '0; rd[1] = '0;
    predict(1'b0, 1'b0, 4'hF, ia, 32'h0, lg[0], be[0], wd[0]);
    predict(1'b1, dwe, dsel, da, dwd, lg[1], be[1], wd[1]);
    if (use_if && use_d) first = (DF || !last_d) ? 1 : 0;
    else first = use_d ? 1 : 0;
    nxt = 0;
    last_t = 0;
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? first : 1 - first;
      if (use_p[p]) begin
        eff = (w[p] < MW) ? w[p] : MW - 1;
        g[p] = nxt;
        if (!lg[p]) begin
          ac[p] = nxt + 2;
          er[p] = 1'b1;
        end else begin
          waits.push_back(w[p]);
          ac[p] = nxt + 2 + eff;
          er[p] = (w[p] >= MW);
          rd[p] = er[p] ? 32'h0 : ref_mem[ad[p][9:2]];
          if (!er[p] && we[p])
            for (int b = 0; b < 4; b++)
              if (be[p][b]) ref_mem[ad[p][9:2]][8*b +: 8] = wd[p][8*b +: 8];
        end
        last_d = (p == 1);
        nxt = ac[p] + 1;
        last_t = ac[p];
      end
    end

    if_req = use_if; if_addr = ia;
    d_req = use_d; d_we = dwe; d_sel = dsel; d_addr = da; d_wdata = dwd;
    #1;
    check("stall_t0", 32'(stall_req), 32'(use_if | use_d));
    for (int t = 1; t <= last_t; t++) begin
      @(posedge clk); #1;
      en_exp = 1'b0;
      for (int p = 0; p < 2; p++)
        if (use_p[p] && lg[p] && t > g[p] && t < ac[p]) en_exp = 1'b1;
      check("ram_en", 32'(ram_en), 32'(en_exp));
      check("if_ack", 32'(if_ack), 32'(use_p[0] && t == ac[0]));
      check("d_ack", 32'(d_ack), 32'(use_p[1] && t == ac[1]));
      check("stall_req", 32'(stall_req),
            32'((use_p[0] && t < ac[0]) || (use_p[1] && t < ac[1])));
      for (int p = 0; p < 2; p++)
        if (use_p[p] && lg[p] && t == g[p] + 1) begin
          check("ram_addr", ram_addr, {ad[p][31:2], 2'b00});
          check("ram_we", 32'(ram_we), 32'(be[p]));
          if (we[p]) check("ram_wdata", ram_wdata, wd[p]);
        end
      if (use_p[0] && t == ac[0]) begin
        check("if_err", 32'(if_err), 32'(er[0]));
        if (lg[0]) check("if_rdata", if_rdata, rd[0]);
        if_req = 1'b0;
      end
      if (use_p[1] && t == ac[1]) begin
        check("d_err", 32'(d_err), 32'(er[1]));
        if (lg[1]) check("d_rdata", d_rdata, rd[1]);
        d_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("idle_ram_en", 32'(ram_en), 32'h0);
  endtask

  task automatic check_outputs_zero();
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_acks", 32'({if_ack, d_ack}), 32'h0);
    check("rst_errs", 32'({if_err, d_err}), 32'h0);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  sel;
    int          mode, r, wi, wdd;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero();
    rst = 1'b1;

    // tie straight out of reset: data first, fetch three cycles later
    run(1'b1, 32'h200, 0, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0, 0);
    // byte store at an odd address
    run(1'b0, 32'h0, 0, 1'b1, 1'b1, 4'b0001, 32'h103, 32'hAB, 0);
    // misaligned word: never reaches the RAM
    run(1'b0, 32'h0, 0, 1'b1, 1'b0, 4'hF, 32'h6, 32'h0, 0);
    // RAM never ready: fetch aborted after MAX_WAIT cycles
    run(1'b1, 32'h80, 100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0);

    // reset during a load's access, then the held request completes
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h40; d_wdata = '0;
    waits.push_back(10);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_ram_en", 32'(ram_en), 32'h1);
    #2 rst = 1'b0;
    #1;
    check_outputs_zero();
    @(posedge clk); #1;
    rst = 1'b1;
    last_d = 1'b0;
    run(1'b0, 32'h0, 0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 0);

    for (int n = 0; n < 80; n++) begin
      mode = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      r = $urandom_range(0, 7);
      sel = (r < 3) ? 4'b0001 : (r < 5) ? 4'b0011 : (r < 7) ? 4'b1111 : 4'($urandom_range(0, 15));
      wd = $urandom;
      r = $urandom_range(0, 9);
      wi = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? 14 : $urandom_range(15, 20);
      r = $urandom_range(0, 9);
      wdd = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? 14 : $urandom_range(15, 20);
      run(mode != 1, 32'($urandom_range(0, 255)) << ($urandom_range(0, 3) == 0 ? 0 : 2), wi,
          mode != 0, 1'($urandom_range(0, 1)), sel,
          ($urandom_range(0, 1) == 1) ? (a & ~32'h3) | 32'($urandom_range(0, 3)) : a, wd, wdd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
